nibble_serial_adder_ctrl: RTL and testbench

- Sequencing controller that performs wide add/subtract by time-multiplexing one 4-bit ripple-carry adder slice over WORDS nibbles, least significant nibble first.
- Carry is chained between cycles through a carry register.
- Used where area matters more than latency. It is the control and sequencing wrapper around the team's 4-bit ripple adder datapath.
- Start/busy/done handshake toward the requester.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 30 +++
 rtl/nibble_serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle for nibble_serial_adder_ctrl.
// master (requester): drives start/sub/ci/a/b and observes busy/done/valid/sum/cout/ovf.
// slave  (controller): the reverse.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WORDS = 4
) ();
    localparam int unsigned W = 4 * WORDS;

    logic         start;
    logic         sub;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, ci, a, b,
        input  busy, done, valid, sum, cout, ovf
    );

    modport slave (
        input  start, sub, ci, a, b,
        output busy, done, valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built by reusing one 4-bit ripple slice over WORDS nibbles,
// least significant nibble first, with the carry held in a register between cycles.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of nibble_serial_adder_ctrl_if
//          (start/sub/ci/a/b in; busy/done/valid/sum/cout/ovf out, all registered)
module nibble_serial_adder_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);
    localparam int unsigned W  = 4 * WORDS;
    localparam int unsigned IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;       // b already inverted in subtract mode
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          busy_q;
    logic          done_q;
    logic          valid_q;
    logic          cout_q;
    logic          ovf_q;

    logic [IW+1:0] ofs_c;
    logic [3:0]    nib_a_c;
    logic [3:0]    nib_b_c;
    logic [4:0]    slice_c;

    // The single 4-bit ripple slice, fed with the nibble selected by idx_q.
    always_comb begin
        ofs_c   = {idx_q, 2'b00};
        nib_a_c = a_q[ofs_c +: 4];
        nib_b_c = b_q[ofs_c +: 4];
        slice_c = 5'(nib_a_c) + 5'(nib_b_c) + 5'(carry_q);
    end

    // Sequencer: state, operand latches, carry chain and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {W{bus.sub}};
                        // Subtract is a + ~b + 1, so the carry seeds to 1.
                        carry_q <= bus.sub | bus.ci;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[ofs_c +: 4] <= slice_c[3:0];
                    carry_q           <= slice_c[4];
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_c[4];
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (slice_c[3] != a_q[W-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WORDS=4, plus WORDS=2 and WORDS=8 instances.
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WORDS(4)) b4 ();
    nibble_serial_adder_ctrl_if #(.WORDS(2)) b2 ();
    nibble_serial_adder_ctrl_if #(.WORDS(8)) b8 ();

    nibble_serial_adder_ctrl #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    nibble_serial_adder_ctrl #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    nibble_serial_adder_ctrl #(.WORDS(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    // Wide reference: returns {ovf, cout, sum[63:0]} for a w-bit operation.
    function automatic logic [65:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                              input logic s, input logic c);
        logic [63:0] mask;
        logic [63:0] beff;
        logic [64:0] full;
        logic [63:0] res;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        beff = (s ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, beff} + 65'(s | c);
        res  = full[63:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == beff[w-1]) && (res[w-1] != a[w-1]);
        return {ov, co, res};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (b4.busy  !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b4.busy); end
        checks++; if (b4.done  !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", b4.done); end
        checks++; if (b4.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", b4.valid); end
        checks++; if (b4.sum   !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", b4.sum); end
        checks++; if (b4.cout  !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", b4.cout); end
        checks++; if (b4.ovf   !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", b4.ovf); end
        rst = 1'b0;
    endtask

    // One WORDS=4 operation; returns at the negedge of the done cycle.
    task automatic run_op4(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic c,
                           input logic [15:0] esum, input logic ecout, input logic eovf);
        int cyc;
        int nbusy;
        bit seen;
        @(negedge clk);
        b4.start = 1'b1; b4.a = a; b4.b = b; b4.sub = s; b4.ci = c;
        @(negedge clk);
        // Disturb inputs after acceptance; the latched copy must be used.
        b4.start = 1'b0; b4.a = ~a; b4.b = ~b; b4.sub = ~s; b4.ci = ~c;
        cyc = 1; nbusy = 0; seen = 0;
        checks++; if (b4.valid !== 1'b0) begin failures++; $display("FAIL %s valid_drop got=%b exp=0", nm, b4.valid); end
        while (!seen && cyc < 40) begin
            if (b4.done === 1'b1) seen = 1;
            else begin
                if (b4.busy === 1'b1) nbusy++;
                @(negedge clk);
                cyc++;
            end
        end
        checks++; if (!seen || cyc != 5) begin failures++; $display("FAIL %s latency got=%0d exp=5", nm, cyc); end
        checks++; if (nbusy != 4 || b4.busy !== 1'b0) begin failures++; $display("FAIL %s busy got=%0d/%b exp=4/0", nm, nbusy, b4.busy); end
        checks++; if (b4.sum  !== esum) begin failures++; $display("FAIL %s sum got=%h exp=%h", nm, b4.sum, esum); end
        checks++; if (b4.cout !== ecout) begin failures++; $display("FAIL %s cout got=%b exp=%b", nm, b4.cout, ecout); end
        checks++; if (b4.ovf  !== eovf) begin failures++; $display("FAIL %s ovf got=%b exp=%b", nm, b4.ovf, eovf); end
        checks++; if (b4.valid !== 1'b1) begin failures++; $display("FAIL %s valid got=%b exp=1", nm, b4.valid); end
    endtask

    task automatic test_add();
        run_op4("add", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    endtask

    task automatic test_carry_chain();
        run_op4("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op4("carry_ci",   16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_subtract();
        run_op4("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op4("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        b4.start = 1'b1; b4.a = 16'h1111; b4.b = 16'h2222; b4.sub = 1'b0; b4.ci = 1'b0;
        @(negedge clk);
        b4.start = 1'b0;
        @(negedge clk);
        checks++; if (b4.busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", b4.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (b4.busy  !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", b4.busy); end
        checks++; if (b4.done  !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", b4.done); end
        checks++; if (b4.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", b4.valid); end
        checks++; if (b4.sum   !== 16'h0) begin failures++; $display("FAIL midrst_sum got=%h exp=0000", b4.sum); end
        checks++; if (b4.cout  !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b exp=0", b4.cout); end
        checks++; if (b4.ovf   !== 1'b0) begin failures++; $display("FAIL midrst_ovf got=%b exp=0", b4.ovf); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (b4.done !== 1'b0 || b4.busy !== 1'b0) begin
                failures++; $display("FAIL midrst_quiet cyc=%0d done=%b busy=%b exp=0/0", i, b4.done, b4.busy);
            end
        end
        run_op4("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start();
        bit exp_done;
        bit exp_busy;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exp_done = (c == 5) || (c == 11);
            exp_busy = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            checks++; if (b4.done !== exp_done) begin failures++; $display("FAIL ign_done c=%0d got=%b exp=%b", c, b4.done, exp_done); end
            checks++; if (b4.busy !== exp_busy) begin failures++; $display("FAIL ign_busy c=%0d got=%b exp=%b", c, b4.busy, exp_busy); end
            if (c == 5) begin
                checks++; if (b4.sum !== 16'h0002) begin failures++; $display("FAIL ign_sum1 got=%h exp=0002", b4.sum); end
            end
            if (c == 6) begin
                checks++; if (b4.valid !== 1'b1) begin failures++; $display("FAIL ign_valid_hold got=%b exp=1", b4.valid); end
            end
            if (c == 7) begin
                checks++; if (b4.valid !== 1'b0) begin failures++; $display("FAIL ign_valid_drop got=%b exp=0", b4.valid); end
            end
            if (c == 11) begin
                checks++; if (b4.sum !== 16'h00F1) begin failures++; $display("FAIL ign_sum2 got=%h exp=00f1", b4.sum); end
            end
            b4.start = (c < 10);
            if (c == 0) begin b4.a = 16'h0001; b4.b = 16'h0001; b4.sub = 1'b0; b4.ci = 1'b0; end
            if (c == 2) b4.a = 16'h00F0;
        end
    endtask

    task automatic run_op2(input string nm, input logic [63:0] a, input logic [63:0] b, input logic s, input logic c);
        logic [65:0] e;
        int cyc;
        e = ref_model(8, a, b, s, c);
        @(negedge clk);
        b2.start = 1'b1; b2.a = a[7:0]; b2.b = b[7:0]; b2.sub = s; b2.ci = c;
        @(negedge clk);
        b2.start = 1'b0;
        cyc = 1;
        while (b2.done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 3) begin failures++; $display("FAIL %s latency got=%0d exp=3", nm, cyc); end
        checks++; if ({b2.ovf, b2.cout, b2.sum} !== {e[65], e[64], e[7:0]})
            begin failures++; $display("FAIL %s ovf/cout/sum got=%b/%b/%h exp=%b/%b/%h", nm, b2.ovf, b2.cout, b2.sum, e[65], e[64], e[7:0]); end
    endtask

    task automatic run_op8(input string nm, input logic [63:0] a, input logic [63:0] b, input logic s, input logic c);
        logic [65:0] e;
        int cyc;
        e = ref_model(32, a, b, s, c);
        @(negedge clk);
        b8.start = 1'b1; b8.a = a[31:0]; b8.b = b[31:0]; b8.sub = s; b8.ci = c;
        @(negedge clk);
        b8.start = 1'b0;
        cyc = 1;
        while (b8.done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 9) begin failures++; $display("FAIL %s latency got=%0d exp=9", nm, cyc); end
        checks++; if ({b8.ovf, b8.cout, b8.sum} !== {e[65], e[64], e[31:0]})
            begin failures++; $display("FAIL %s ovf/cout/sum got=%b/%b/%h exp=%b/%b/%h", nm, b8.ovf, b8.cout, b8.sum, e[65], e[64], e[31:0]); end
    endtask

    task automatic test_param_sweep();
        run_op2("w2_ovf",   64'h7F, 64'h01, 1'b0, 1'b0);
        run_op2("w2_sub",   64'h05, 64'h09, 1'b1, 1'b0);
        run_op2("w2_ci",    64'hA5, 64'h5A, 1'b0, 1'b1);
        run_op8("w8_wrap",  64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op8("w8_sub",   64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b1);
        run_op8("w8_subov", 64'h8000_0000, 64'h1, 1'b1, 1'b0);
        run_op8("w8_ci",    64'h7FFF_FFFF, 64'h0, 1'b0, 1'b1);
    endtask

    initial begin
        b4.start = 1'b0; b4.sub = 1'b0; b4.ci = 1'b0; b4.a = '0; b4.b = '0;
        b2.start = 1'b0; b2.sub = 1'b0; b2.ci = 1'b0; b2.a = '0; b2.b = '0;
        b8.start = 1'b0; b8.sub = 1'b0; b8.ci = 1'b0; b8.a = '0; b8.b = '0;
        test_reset();
        test_add();
        test_carry_chain();
        test_subtract();
        test_reset_mid_op();
        test_ignored_start();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
